// File: rtl/cam_frame_gen_pkg.sv
// rtl/cam_frame_gen_pkg.sv - shared types and helpers for the camera frame generator
// Purpose : FSM state encoding, test pattern codes, colour-bar RGB444 table and
//           LFSR seed/step helper shared by cam_frame_gen and cam_pattern_gen.
// Ports   : none (package)
// Config  : CAM_GEN_LFSR_EN selects the LFSR variant of pattern 3 in cam_pattern_gen.
package cam_frame_gen_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_VSYNC  = 3'd1,
      ST_VBP    = 3'd2,
      ST_ACTIVE = 3'd3,
      ST_VFP    = 3'd4
   } state_t;

   typedef enum logic [1:0] {
      PAT_BARS    = 2'd0,
      PAT_RAMP    = 2'd1,
      PAT_CHECKER = 2'd2,
      PAT_SOLID   = 2'd3
   } pattern_t;

   // Galois LFSR, polynomial x^12 + x^6 + x^4 + x + 1, right-shifting form
   localparam logic [11:0] LFSR_SEED = 12'hACE;
   localparam logic [11:0] LFSR_TAPS = 12'h829;

   // Colour bars, left to right: white, yellow, cyan, green, magenta, red, blue, black
   function automatic logic [11:0] bar_rgb(input logic [2:0] idx);
      logic [11:0] rgb;
      case (idx)
         3'd0:    rgb = 12'hFFF;
         3'd1:    rgb = 12'hFF0;
         3'd2:    rgb = 12'h0FF;
         3'd3:    rgb = 12'h0F0;
         3'd4:    rgb = 12'hF0F;
         3'd5:    rgb = 12'hF00;
         3'd6:    rgb = 12'h00F;
         default: rgb = 12'h000;
      endcase
      return rgb;
   endfunction

   function automatic logic [11:0] lfsr_step(input logic [11:0] s);
      return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
   endfunction

endpackage

// File: rtl/cam_frame_gen_if.sv
// rtl/cam_frame_gen_if.sv - OV7670-style parallel video bus (vsync/href/byte)
// Purpose : groups the sensor-side video signals driven by cam_frame_gen.
// Signals : vsync    frame sync
//           href     line valid, high during active bytes
//           pix_byte pixel byte (RGB444, two bytes per pixel)
// Modports: master (frame source), slave (capture side)
interface cam_frame_gen_if;
   logic       vsync;
   logic       href;
   logic [7:0] pix_byte;

   modport master (output vsync, output href, output pix_byte);
   modport slave  (input  vsync, input  href, input  pix_byte);
endinterface

// File: rtl/cam_frame_gen_pattern_gen.sv
// rtl/cam_frame_gen_pattern_gen.sv - test pattern byte generator for cam_frame_gen
// Purpose : maps (x, y, pattern, solid, byte_sel) to one RGB444 pixel byte.
// Ports   : i_clk, i_rstn      clock / async active-low reset (LFSR only)
//           i_x, i_y           pixel column / active line index
//           i_pattern          pattern code for the current frame
//           i_solid            {R,G,B} for pattern 3 (solid variant)
//           i_byte_sel         0 -> {4'h0,R}, 1 -> {G,B}
//           i_lfsr_load        reload LFSR seed (frame start)
//           i_lfsr_adv         step LFSR (odd byte of an active pixel)
//           o_byte             pixel byte
// Config  : CAM_GEN_LFSR_EN defined -> pattern 3 is a 12-bit LFSR, i_solid ignored.
module cam_pattern_gen
   import cam_frame_gen_pkg::*;
#(
   parameter int H_ACTIVE = 640,
   parameter int XW       = 10,
   parameter int YW       = 9
) (
   input  logic          i_clk,
   input  logic          i_rstn,
   input  logic [XW-1:0] i_x,
   input  logic [YW-1:0] i_y,
   input  pattern_t      i_pattern,
   input  logic [11:0]   i_solid,
   input  logic          i_byte_sel,
   input  logic          i_lfsr_load,
   input  logic          i_lfsr_adv,
   output logic [7:0]    o_byte
);

   localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

   logic [31:0] w_xi;
   logic [31:0] w_yi;
   logic [31:0] w_bar;
   logic [31:0] w_ramp;
   logic [3:0]  w_lvl;
   logic [11:0] w_solid_src;
   logic [11:0] w_rgb;
   logic        w_unused;

   assign w_xi   = 32'(i_x);
   assign w_yi   = 32'(i_y);
   assign w_bar  = w_xi / BAR_W;
   assign w_ramp = (w_xi << 4) / H_ACTIVE;
   assign w_lvl  = (w_ramp > 32'd15) ? 4'hF : w_ramp[3:0];

`ifdef CAM_GEN_LFSR_EN
   logic [11:0] r_lfsr;

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_lfsr <= LFSR_SEED;
      end else if (i_lfsr_load) begin
         r_lfsr <= LFSR_SEED;
      end else if (i_lfsr_adv) begin
         r_lfsr <= lfsr_step(r_lfsr);
      end
   end

   assign w_solid_src = r_lfsr;
   assign w_unused    = &{1'b0, i_solid, w_yi};
`else
   assign w_solid_src = i_solid;
   assign w_unused    = &{1'b0, i_clk, i_rstn, i_lfsr_load, i_lfsr_adv, w_yi};
`endif

   always_comb begin
      w_rgb = 12'h000;
      case (i_pattern)
         PAT_BARS:    w_rgb = bar_rgb((w_bar > 32'd7) ? 3'd7 : w_bar[2:0]);
         PAT_RAMP:    w_rgb = {w_lvl, w_lvl, w_lvl};
         PAT_CHECKER: w_rgb = (w_xi[3] ^ w_yi[3]) ? 12'hFFF : 12'h000;
         default:     w_rgb = w_solid_src;
      endcase
   end

   assign o_byte = i_byte_sel ? w_rgb[7:0] : {4'h0, w_rgb[11:8]};

endmodule

// File: rtl/cam_frame_gen.sv
// rtl/cam_frame_gen.sv - OV7670-compatible test frame source (vsync/href/RGB444 bytes)
// Purpose : stands in for the camera on the pclk side; produces frames of
//           selectable test patterns with sensor-like sync timing.
// Ports   : i_clk         pixel-byte clock, one byte per cycle
//           i_rstn        asynchronous active-low reset
//           i_en          run request, sampled in IDLE and at each frame end
//           i_pattern     0 bars, 1 ramp, 2 checker, 3 solid/LFSR
//           i_solid_rgb   {R,G,B} for pattern 3 (solid variant)
//           cam           video bus master: vsync, href, pix_byte
//           o_frame_done  one-cycle pulse on the last clock of the front porch
//           o_busy        high whenever not IDLE
// Config  : CAM_GEN_LFSR_EN defined -> pattern 3 is an LFSR reseeded every frame.
module cam_frame_gen
   import cam_frame_gen_pkg::*;
#(
   parameter int H_ACTIVE = 640,
   parameter int H_BLANK  = 144,
   parameter int V_ACTIVE = 480,
   parameter int V_SYNC   = 3,
   parameter int V_BP     = 17,
   parameter int V_FP     = 10
) (
   input  logic        i_clk,
   input  logic        i_rstn,
   input  logic        i_en,
   input  logic [1:0]  i_pattern,
   input  logic [11:0] i_solid_rgb,
   cam_frame_gen_if.master cam,
   output logic        o_frame_done,
   output logic        o_busy
);

   localparam int LINE_LEN = 2 * (H_ACTIVE + H_BLANK);
   localparam int H_W      = $clog2(LINE_LEN);
   localparam int V_MAX_A  = (V_ACTIVE > V_SYNC) ? V_ACTIVE : V_SYNC;
   localparam int V_MAX_B  = (V_BP > V_FP) ? V_BP : V_FP;
   localparam int V_MAX    = (V_MAX_A > V_MAX_B) ? V_MAX_A : V_MAX_B;
   localparam int V_W      = (V_MAX > 1) ? $clog2(V_MAX) : 1;

   state_t         r_state;
   logic [H_W-1:0] r_h_cnt;
   logic [V_W-1:0] r_v_cnt;
   pattern_t       r_pattern;
   logic [11:0]    r_solid;

   logic           r_vsync;
   logic           r_href;
   logic [7:0]     r_pix;
   logic           r_done;
   logic           r_busy;

   state_t         w_state_nxt;
   logic [H_W-1:0] w_h_nxt;
   logic [V_W-1:0] w_v_nxt;
   logic           w_h_wrap;
   logic           w_v_last;
   logic           w_enter_vsync;
   logic           w_href_nxt;
   logic           w_done_nxt;
   logic [7:0]     w_pix_byte;

   assign w_h_wrap = (r_h_cnt == H_W'(LINE_LEN - 1));

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_state <= ST_IDLE;
         r_h_cnt <= '0;
         r_v_cnt <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_h_cnt <= w_h_nxt;
         r_v_cnt <= w_v_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_h_nxt       = r_h_cnt;
      w_v_nxt       = r_v_cnt;
      w_enter_vsync = 1'b0;
      w_v_last      = 1'b0;
      w_href_nxt    = 1'b0;
      w_done_nxt    = 1'b0;

      case (r_state)
         ST_VSYNC:  w_v_last = (r_v_cnt == V_W'(V_SYNC - 1));
         ST_VBP:    w_v_last = (r_v_cnt == V_W'(V_BP - 1));
         ST_ACTIVE: w_v_last = (r_v_cnt == V_W'(V_ACTIVE - 1));
         ST_VFP:    w_v_last = (r_v_cnt == V_W'(V_FP - 1));
         default:   w_v_last = 1'b0;
      endcase

      if (r_state == ST_IDLE) begin
         if (i_en) begin
            w_state_nxt   = ST_VSYNC;
            w_h_nxt       = '0;
            w_v_nxt       = '0;
            w_enter_vsync = 1'b1;
         end
      end else if (w_h_wrap) begin
         // states only change on a line boundary, so every line has equal length
         w_h_nxt = '0;
         if (w_v_last) begin
            w_v_nxt = '0;
            case (r_state)
               ST_VSYNC:  w_state_nxt = ST_VBP;
               ST_VBP:    w_state_nxt = ST_ACTIVE;
               ST_ACTIVE: w_state_nxt = ST_VFP;
               default: begin
                  if (i_en) begin
                     w_state_nxt   = ST_VSYNC;
                     w_enter_vsync = 1'b1;
                  end else begin
                     w_state_nxt = ST_IDLE;
                  end
               end
            endcase
         end else begin
            w_v_nxt = r_v_cnt + 1'b1;
         end
      end else begin
         w_h_nxt = r_h_cnt + 1'b1;
      end

      // outputs are decoded from the next-state values so the registered
      // outputs line up with the state/counter registers
      w_href_nxt = (w_state_nxt == ST_ACTIVE) && (w_h_nxt < H_W'(2 * H_ACTIVE));
      w_done_nxt = (w_state_nxt == ST_VFP) && (w_h_nxt == H_W'(LINE_LEN - 1)) &&
                   (w_v_nxt == V_W'(V_FP - 1));
   end

   // pattern selection is frozen for the whole frame at VSYNC entry
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_pattern <= PAT_BARS;
         r_solid   <= 12'h000;
      end else if (w_enter_vsync) begin
         r_pattern <= pattern_t'(i_pattern);
         r_solid   <= i_solid_rgb;
      end
   end

   cam_pattern_gen #(
      .H_ACTIVE (H_ACTIVE),
      .XW       (H_W - 1),
      .YW       (V_W)
   ) u_pattern (
      .i_clk       (i_clk),
      .i_rstn      (i_rstn),
      .i_x         (w_h_nxt[H_W-1:1]),
      .i_y         (w_v_nxt),
      .i_pattern   (r_pattern),
      .i_solid     (r_solid),
      .i_byte_sel  (w_h_nxt[0]),
      .i_lfsr_load (w_enter_vsync),
      .i_lfsr_adv  (w_href_nxt & w_h_nxt[0]),
      .o_byte      (w_pix_byte)
   );

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_vsync <= 1'b0;
         r_href  <= 1'b0;
         r_pix   <= 8'h00;
         r_done  <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_vsync <= (w_state_nxt == ST_VSYNC);
         r_href  <= w_href_nxt;
         r_pix   <= w_href_nxt ? w_pix_byte : 8'h00;
         r_done  <= w_done_nxt;
         r_busy  <= (w_state_nxt != ST_IDLE);
      end
   end

   assign cam.vsync     = r_vsync;
   assign cam.href      = r_href;
   assign cam.pix_byte  = r_pix;
   assign o_frame_done  = r_done;
   assign o_busy        = r_busy;

endmodule

// File: tb/tb_cam_frame_gen.sv
// tb/tb_cam_frame_gen.sv - self-checking bench for cam_frame_gen
module tb_cam_frame_gen;

   localparam int HA  = 8;
   localparam int HB  = 2;
   localparam int VA  = 4;
   localparam int VS  = 1;
   localparam int VBP = 1;
   localparam int VFP = 1;
   localparam int L   = 2 * (HA + HB);
   localparam int F   = L * (VS + VBP + VA + VFP);

   logic        clk = 1'b0;
   logic        rstn;
   logic        en;
   logic [1:0]  pat;
   logic [11:0] solid;
   logic        done;
   logic        busy;

   cam_frame_gen_if cam_if ();

   cam_frame_gen #(
      .H_ACTIVE (HA), .H_BLANK (HB), .V_ACTIVE (VA),
      .V_SYNC   (VS), .V_BP    (VBP), .V_FP    (VFP)
   ) dut (
      .i_clk        (clk),
      .i_rstn       (rstn),
      .i_en         (en),
      .i_pattern    (pat),
      .i_solid_rgb  (solid),
      .cam          (cam_if),
      .o_frame_done (done),
      .o_busy       (busy)
   );

   always #5 clk = ~clk;

   int n_total = 0;
   int n_bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model: frame position arithmetic ----------------
   bit          running = 1'b0;
   int          p = 0;
   logic [1:0]  m_pat = 2'd0;
   logic [11:0] m_solid = 12'h000;
   logic [11:0] m_lfsr = 12'hACE;
   logic [11:0] bar_tab [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                                12'hF0F, 12'hF00, 12'h00F, 12'h000};

   function automatic logic [11:0] lfsr_next(input logic [11:0] s);
      logic [11:0] n;
      n = {1'b0, s[11:1]};
      if (s[0]) begin
         n[11] = ~n[11];
         n[5]  = ~n[5];
         n[3]  = ~n[3];
         n[0]  = ~n[0];
      end
      return n;
   endfunction

   function automatic bit href_at(input int pos);
      int line = pos / L;
      int col  = pos % L;
      return (line >= VS + VBP) && (line < VS + VBP + VA) && (col < 2 * HA);
   endfunction

   function automatic logic [7:0] byte_at(input int pos, input logic [1:0] pt,
                                         input logic [11:0] sol, input logic [11:0] lf);
      int x, y, lvl, bw;
      logic [11:0] rgb;
      if (!href_at(pos)) return 8'h00;
      x  = (pos % L) / 2;
      y  = pos / L - (VS + VBP);
      bw = (HA / 8 > 0) ? HA / 8 : 1;
      case (pt)
         2'd0: rgb = bar_tab[(x / bw > 7) ? 7 : x / bw];
         2'd1: begin
            lvl = (x * 16) / HA;
            if (lvl > 15) lvl = 15;
            rgb = {3{lvl[3:0]}};
         end
         2'd2: rgb = (((x / 8) ^ (y / 8)) % 2 == 1) ? 12'hFFF : 12'h000;
`ifdef CAM_GEN_LFSR_EN
         default: rgb = lf;
`else
         default: rgb = sol;
`endif
      endcase
      return ((pos % L) % 2 == 1) ? rgb[7:0] : {4'h0, rgb[11:8]};
   endfunction

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         running = 1'b0;
         p       = 0;
      end else begin
         if (running && href_at(p) && ((p % L) % 2 == 1)) m_lfsr = lfsr_next(m_lfsr);
         if (!running || p == F - 1) begin
            if (en) begin
               running = 1'b1;
               p       = 0;
               m_pat   = pat;
               m_solid = solid;
               m_lfsr  = 12'hACE;
            end else begin
               running = 1'b0;
            end
         end else begin
            p++;
         end
      end
   end

   always @(negedge clk) begin
      chk("vsync", {31'b0, cam_if.vsync}, {31'b0, running && (p / L < VS)});
      chk("href",  {31'b0, cam_if.href},  {31'b0, running && href_at(p)});
      chk("pix",   {24'b0, cam_if.pix_byte}, {24'b0, running ? byte_at(p, m_pat, m_solid, m_lfsr) : 8'h00});
      chk("done",  {31'b0, done}, {31'b0, running && (p == F - 1)});
      chk("busy",  {31'b0, busy}, {31'b0, running});
   end

   // ---------------- directed stimulus with hand-computed literals ----------------
   int hc;
   int fd;

   initial begin
      rstn  = 1'b0;
      en    = 1'b0;
      pat   = 2'd0;
      solid = 12'h000;
      hc    = 0;
      fd    = 0;
      repeat (3) @(negedge clk);
      chk("rst_vsync", {31'b0, cam_if.vsync}, 32'd0);
      chk("rst_href",  {31'b0, cam_if.href},  32'd0);
      chk("rst_pix",   {24'b0, cam_if.pix_byte}, 32'd0);
      chk("rst_busy",  {31'b0, busy}, 32'd0);
      en   = 1'b1;
      rstn = 1'b1;

      for (int k = 1; k <= 650; k++) begin
         @(posedge clk);
         #1;
         if (k <= 140 && cam_if.href) hc++;
         if (k >= 421 && k <= 600 && done) fd++;
         case (k)
            1:   begin chk("t1_vsync_rise", {31'b0, cam_if.vsync}, 32'd1);
                       chk("t1_busy", {31'b0, busy}, 32'd1); end
            20:  chk("t1_vsync_end", {31'b0, cam_if.vsync}, 32'd1);
            21:  chk("t1_vsync_fall", {31'b0, cam_if.vsync}, 32'd0);
            40:  chk("t1_href_pre", {31'b0, cam_if.href}, 32'd0);
            41:  begin chk("t1_href_rise", {31'b0, cam_if.href}, 32'd1);
                       chk("t1_bar0_b0", {24'b0, cam_if.pix_byte}, 32'h0F); end
            42:  chk("t1_bar0_b1", {24'b0, cam_if.pix_byte}, 32'hFF);
            43:  chk("t1_bar1_b0", {24'b0, cam_if.pix_byte}, 32'h0F);
            44:  chk("t1_bar1_b1", {24'b0, cam_if.pix_byte}, 32'hF0);
            50:  pat = 2'd2;
            56:  chk("t1_href_last", {31'b0, cam_if.href}, 32'd1);
            57:  begin chk("t1_href_fall", {31'b0, cam_if.href}, 32'd0);
                       chk("t1_blank_pix", {24'b0, cam_if.pix_byte}, 32'h00); end
            139: chk("t1_done_pre", {31'b0, done}, 32'd0);
            140: begin chk("t1_done", {31'b0, done}, 32'd1);
                       chk("t1_href_cnt", hc, 32'd64); end
            141: chk("t2_vsync", {31'b0, cam_if.vsync}, 32'd1);
            181: begin chk("t2_href", {31'b0, cam_if.href}, 32'd1);
                       chk("t2_chk_pix", {24'b0, cam_if.pix_byte}, 32'h00); end
            200: begin pat = 2'd3; solid = 12'h5A3; end
`ifdef CAM_GEN_LFSR_EN
            321: chk("t6_lfsr_b0", {24'b0, cam_if.pix_byte}, 32'h0A);
            322: chk("t6_lfsr_b1", {24'b0, cam_if.pix_byte}, 32'hCE);
`else
            321: chk("t3_solid_b0", {24'b0, cam_if.pix_byte}, 32'h05);
            322: chk("t3_solid_b1", {24'b0, cam_if.pix_byte}, 32'hA3);
            323: chk("t3_solid_b0b", {24'b0, cam_if.pix_byte}, 32'h05);
`endif
            330: pat = 2'd1;
            463: chk("t4_ramp_b0", {24'b0, cam_if.pix_byte}, 32'h02);
            464: chk("t4_ramp_b1", {24'b0, cam_if.pix_byte}, 32'h22);
            485: en = 1'b0;
            560: chk("t4_done", {31'b0, done}, 32'd1);
            561: begin chk("t4_busy_fall", {31'b0, busy}, 32'd0);
                       chk("t4_vsync_low", {31'b0, cam_if.vsync}, 32'd0); end
            580: chk("t4_idle_vsync", {31'b0, cam_if.vsync}, 32'd0);
            600: begin chk("t4_done_once", fd, 32'd1); en = 1'b1; end
            601: chk("t5_restart", {31'b0, cam_if.vsync}, 32'd1);
            default: ;
         endcase
      end

      // asynchronous reset in the middle of an active line
      #1 rstn = 1'b0;
      #1;
      chk("t5_rst_vsync", {31'b0, cam_if.vsync}, 32'd0);
      chk("t5_rst_href",  {31'b0, cam_if.href},  32'd0);
      chk("t5_rst_pix",   {24'b0, cam_if.pix_byte}, 32'd0);
      chk("t5_rst_done",  {31'b0, done}, 32'd0);
      chk("t5_rst_busy",  {31'b0, busy}, 32'd0);
      repeat (3) @(negedge clk);
      rstn = 1'b1;

      for (int k = 1; k <= 145; k++) begin
         @(posedge clk);
         #1;
         case (k)
            1:   chk("t5_vsync_rise", {31'b0, cam_if.vsync}, 32'd1);
            41:  chk("t5_href_rise", {31'b0, cam_if.href}, 32'd1);
            43:  chk("t5_ramp_b0", {24'b0, cam_if.pix_byte}, 32'h02);
            140: chk("t5_done", {31'b0, done}, 32'd1);
            default: ;
         endcase
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
